// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizes for the SRAM burst controller.
// Word address is split into an 11-bit row (RA) and a 4-bit column (CA).
package sram_ctrl_pkg;

  localparam int unsigned ADDRESSSIZE = 15;
  localparam int unsigned WORDSIZE    = 96;
  localparam int unsigned LENSIZE     = 4;
  localparam int unsigned RA_W        = 11;
  localparam int unsigned CA_W        = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead
  } state_e;

  typedef struct packed {
    logic [WORDSIZE-1:0] data;
    logic                last;
  } rd_entry_t;

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Client-side handshake bundle of the SRAM burst controller.
// master = client (datapath), slave = controller.
interface sram_burst_ctrl_if;
  import sram_ctrl_pkg::*;

  logic                   iReqValid;
  logic                   oReqReady;
  logic                   iReqWrite;
  logic [ADDRESSSIZE-1:0] iReqAddr;
  logic [LENSIZE-1:0]     iReqLen;
  logic                   iWrValid;
  logic                   oWrReady;
  logic [WORDSIZE-1:0]    iWrData;
  logic                   oRdValid;
  logic                   iRdReady;
  logic [WORDSIZE-1:0]    oRdData;
  logic                   oRdLast;
  logic                   oBusy;

  modport master (
    output iReqValid, iReqWrite, iReqAddr, iReqLen, iWrValid, iWrData, iRdReady,
    input  oReqReady, oWrReady, oRdValid, oRdData, oRdLast, oBusy
  );

  modport slave (
    input  iReqValid, iReqWrite, iReqAddr, iReqLen, iWrValid, iWrData, iRdReady,
    output oReqReady, oWrReady, oRdValid, oRdData, oRdLast, oBusy
  );

endinterface

// File: rtl/sram_rd_fifo.sv
// Read-return FIFO: Depth entries of {data, last}, show-ahead head, occupancy count.
// Storage is reset too, so the head reads as zero straight after reset.
module sram_rd_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       iClk,
  input  logic                       iReset,
  input  logic                       push_i,
  input  rd_entry_t                  push_data_i,
  input  logic                       pop_i,
  output rd_entry_t                  head_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  rd_entry_t           mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                push_ok, pop_ok;

  assign push_ok = push_i && (count_q < CntW'(Depth));
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller for a 32768x96 single-port SRAM with registered read data.
// Optional beat statistics are built when SRAM_CTRL_STATS_EN is defined.
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned RDFIFO_DEPTH = 4
) (
  input  logic                iClk,
  input  logic                iReset,
  sram_burst_ctrl_if.slave    bus,
  output logic                oNCE,
  output logic                oNWRT,
  output logic [RA_W-1:0]     oRA,
  output logic [CA_W-1:0]     oCA,
  output logic [WORDSIZE-1:0] oDIN,
  input  logic [WORDSIZE-1:0] iDO,
  output logic [15:0]         oWrBeatCnt,
  output logic [15:0]         oRdBeatCnt
);

  localparam int unsigned CntW = $clog2(RDFIFO_DEPTH) + 1;

  state_e                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] addr_q, addr_d;
  logic [LENSIZE-1:0]     rem_q, rem_d;
  logic                   nce_q, nce_d;
  logic                   nwrt_q, nwrt_d;
  logic [RA_W-1:0]        ra_q, ra_d;
  logic [CA_W-1:0]        ca_q, ca_d;
  logic [WORDSIZE-1:0]    din_q, din_d;
  logic                   tag1_vld_q, tag1_vld_d, tag1_last_q, tag1_last_d;
  logic                   tag2_vld_q, tag2_vld_d, tag2_last_q, tag2_last_d;

  logic                   req_fire;
  logic                   fifo_pop;
  logic [CntW-1:0]        fifo_count;
  rd_entry_t              fifo_head;
  rd_entry_t              fifo_push_data;
  logic [1:0]             inflight;
  logic [CntW:0]          occupancy;
  logic                   credit;

  assign req_fire = bus.iReqValid && (state_q == StIdle);
  assign inflight = {1'b0, tag1_vld_q} + {1'b0, tag2_vld_q};
  // Beats already issued count against FIFO space so a capture never finds it full.
  assign occupancy = {1'b0, fifo_count} + (CntW+1)'(inflight);
  assign credit    = occupancy < (CntW+1)'(RDFIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    nce_d       = 1'b1;
    nwrt_d      = 1'b1;
    ra_d        = ra_q;
    ca_d        = ca_q;
    din_d       = din_q;
    tag1_vld_d  = 1'b0;
    tag1_last_d = 1'b0;
    tag2_vld_d  = tag1_vld_q;
    tag2_last_d = tag1_last_q;
    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          addr_d  = bus.iReqAddr;
          rem_d   = bus.iReqLen;
          state_d = bus.iReqWrite ? StWrite : StRead;
        end
      end
      StWrite: begin
        if (bus.iWrValid) begin
          nce_d        = 1'b0;
          nwrt_d       = 1'b0;
          {ra_d, ca_d} = addr_q;
          din_d        = bus.iWrData;
          addr_d       = addr_q + ADDRESSSIZE'(1);
          rem_d        = rem_q - LENSIZE'(1);
          if (rem_q == '0) state_d = StIdle;
        end
      end
      StRead: begin
        if (credit) begin
          nce_d        = 1'b0;
          {ra_d, ca_d} = addr_q;
          tag1_vld_d   = 1'b1;
          tag1_last_d  = (rem_q == '0);
          addr_d       = addr_q + ADDRESSSIZE'(1);
          rem_d        = rem_q - LENSIZE'(1);
          if (rem_q == '0) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rem_q       <= '0;
      nce_q       <= 1'b1;
      nwrt_q      <= 1'b1;
      ra_q        <= '0;
      ca_q        <= '0;
      din_q       <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_last_q <= 1'b0;
      tag2_vld_q  <= 1'b0;
      tag2_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      nce_q       <= nce_d;
      nwrt_q      <= nwrt_d;
      ra_q        <= ra_d;
      ca_q        <= ca_d;
      din_q       <= din_d;
      tag1_vld_q  <= tag1_vld_d;
      tag1_last_q <= tag1_last_d;
      tag2_vld_q  <= tag2_vld_d;
      tag2_last_q <= tag2_last_d;
    end
  end

  // Stage 2 lines up with the SRAM's registered output for that beat.
  assign fifo_push_data.data = iDO;
  assign fifo_push_data.last = tag2_last_q;
  assign fifo_pop            = bus.oRdValid && bus.iRdReady;

  sram_rd_fifo #(
    .Depth (RDFIFO_DEPTH)
  ) u_rd_fifo (
    .iClk        (iClk),
    .iReset      (iReset),
    .push_i      (tag2_vld_q),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign bus.oReqReady = (state_q == StIdle);
  assign bus.oWrReady  = (state_q == StWrite);
  assign bus.oRdValid  = (fifo_count != '0);
  assign bus.oRdData   = fifo_head.data;
  assign bus.oRdLast   = fifo_head.last;
  assign bus.oBusy     = (state_q != StIdle) || (inflight != 2'd0) || (fifo_count != '0);

  assign oNCE  = nce_q;
  assign oNWRT = nwrt_q;
  assign oRA   = ra_q;
  assign oCA   = ca_q;
  assign oDIN  = din_q;

`ifdef SRAM_CTRL_STATS_EN
  logic        wr_beat;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;

  assign wr_beat = (state_q == StWrite) && bus.iWrValid;

  always_comb begin
    wr_cnt_d = wr_cnt_q + {15'd0, wr_beat};
    rd_cnt_d = rd_cnt_q + {15'd0, fifo_pop};
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign oWrBeatCnt = wr_cnt_q;
  assign oRdBeatCnt = rd_cnt_q;
`else
  assign oWrBeatCnt = '0;
  assign oRdBeatCnt = '0;
`endif

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl: SRAM behavioural model, write/read
// vector table with a read-data scoreboard, plus stall, backpressure and reset sequences.
module tb_sram_burst_ctrl;
  import sram_ctrl_pkg::*;

  logic                iClk;
  logic                iReset;
  logic                oNCE, oNWRT;
  logic [RA_W-1:0]     oRA;
  logic [CA_W-1:0]     oCA;
  logic [WORDSIZE-1:0] oDIN;
  logic [WORDSIZE-1:0] iDO;
  logic [15:0]         oWrBeatCnt, oRdBeatCnt;

  sram_burst_ctrl_if bus ();

  sram_burst_ctrl #(
    .RDFIFO_DEPTH (4)
  ) u_dut (
    .iClk       (iClk),
    .iReset     (iReset),
    .bus        (bus),
    .oNCE       (oNCE),
    .oNWRT      (oNWRT),
    .oRA        (oRA),
    .oCA        (oCA),
    .oDIN       (oDIN),
    .iDO        (iDO),
    .oWrBeatCnt (oWrBeatCnt),
    .oRdBeatCnt (oRdBeatCnt)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Behavioural SRAM: active-low pins sampled on the rising edge, registered read data.
  logic [WORDSIZE-1:0] sram [0:32767];
  logic [WORDSIZE-1:0] do_q;
  assign iDO = do_q;
  always @(posedge iClk) begin
    if (!oNCE) begin
      if (!oNWRT) sram[{oRA, oCA}] <= oDIN;
      else        do_q <= sram[{oRA, oCA}];
    end
  end

  typedef struct packed {
    logic [WORDSIZE-1:0] data;
    logic                last;
  } sb_t;

  typedef struct {
    logic                   wr;
    logic [ADDRESSSIZE-1:0] addr;
    logic [LENSIZE-1:0]     len;
    logic [WORDSIZE-1:0]    base;
  } vec_t;

  sb_t                 sb_q [$];
  logic [WORDSIZE-1:0] exp_mem [logic [ADDRESSSIZE-1:0]];
  int                  n_tests = 0;
  int                  n_fail  = 0;
  int                  tb_wr_beats = 0;
  int                  tb_rd_pops  = 0;

  task automatic check(input string name, input logic [WORDSIZE-1:0] act,
                       input logic [WORDSIZE-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every popped beat must match the oldest expected beat.
  always @(negedge iClk) begin
    if (!iReset && bus.oRdValid && bus.iRdReady) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rd_beat", 1'b1, 1'b0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("rd_data", bus.oRdData, e.data);
        check("rd_last", bus.oRdLast, e.last);
      end
      tb_rd_pops++;
    end
  end

  task automatic send_req(input logic wr, input logic [ADDRESSSIZE-1:0] a,
                          input logic [LENSIZE-1:0] l);
    int n = 0;
    while (!bus.oReqReady && n < 100) begin
      @(posedge iClk); #1; n++;
    end
    check("req_ready_wait", bus.oReqReady, 1'b1);
    bus.iReqValid = 1'b1;
    bus.iReqWrite = wr;
    bus.iReqAddr  = a;
    bus.iReqLen   = l;
    @(posedge iClk); #1;
    bus.iReqValid = 1'b0;
  endtask

  task automatic wr_beat(input logic [ADDRESSSIZE-1:0] a, input logic [WORDSIZE-1:0] d);
    int n = 0;
    while (!bus.oWrReady && n < 50) begin
      @(posedge iClk); #1; n++;
    end
    check("wr_ready_wait", bus.oWrReady, 1'b1);
    bus.iWrValid = 1'b1;
    bus.iWrData  = d;
    @(posedge iClk); #1;
    bus.iWrValid = 1'b0;
    check("wr_nce", oNCE, 1'b0);
    check("wr_nwrt", oNWRT, 1'b0);
    check("wr_addr", {oRA, oCA}, a);
    check("wr_din", oDIN, d);
    exp_mem[a] = d;
    tb_wr_beats++;
  endtask

  task automatic rd_req(input logic [ADDRESSSIZE-1:0] a, input logic [LENSIZE-1:0] l);
    int  lat = 0;
    logic quiet;
    for (int i = 0; i <= int'(l); i++) begin
      logic [ADDRESSSIZE-1:0] ba;
      sb_t e;
      ba     = a + ADDRESSSIZE'(i);
      e.data = exp_mem[ba];
      e.last = (i == int'(l));
      sb_q.push_back(e);
    end
    quiet = !bus.oBusy;
    send_req(1'b0, a, l);
    if (quiet) begin
      while (!bus.oRdValid && lat < 10) begin
        @(posedge iClk); #1; lat++;
        if (lat == 1) begin
          check("rd_issue_nce", oNCE, 1'b0);
          check("rd_issue_nwrt", oNWRT, 1'b1);
          check("rd_issue_addr", {oRA, oCA}, a);
        end
      end
      check("rd_latency", lat, 3);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || bus.oBusy) && n < 300) begin
      @(posedge iClk); #1; n++;
    end
    check("drain", (sb_q.size() == 0) && !bus.oBusy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs [7];

  initial begin
    vecs[0] = '{wr: 1'b1, addr: 15'h0010, len: 4'd3,  base: 96'hA0};
    vecs[1] = '{wr: 1'b0, addr: 15'h0010, len: 4'd3,  base: 96'h0};
    vecs[2] = '{wr: 1'b1, addr: 15'h7FFF, len: 4'd1,  base: 96'hB0};
    vecs[3] = '{wr: 1'b0, addr: 15'h0000, len: 4'd0,  base: 96'h0};
    vecs[4] = '{wr: 1'b1, addr: 15'h1234, len: 4'd15, base: 96'hC0DE_0000_0000_0000_0000_0C00};
    vecs[5] = '{wr: 1'b0, addr: 15'h7FFF, len: 4'd1,  base: 96'h0};
    vecs[6] = '{wr: 1'b0, addr: 15'h1234, len: 4'd15, base: 96'h0};

    bus.iReqValid = 1'b0;
    bus.iReqWrite = 1'b0;
    bus.iReqAddr  = '0;
    bus.iReqLen   = '0;
    bus.iWrValid  = 1'b0;
    bus.iWrData   = '0;
    bus.iRdReady  = 1'b1;
    iReset        = 1'b1;
    repeat (3) @(posedge iClk);
    #1 iReset = 1'b0;
    @(posedge iClk); #1;

    check("rst_nce", oNCE, 1'b1);
    check("rst_nwrt", oNWRT, 1'b1);
    check("rst_req_ready", bus.oReqReady, 1'b1);
    check("rst_busy", bus.oBusy, 1'b0);
    check("rst_rd_valid", bus.oRdValid, 1'b0);
    check("rst_addr_pins", {oRA, oCA}, 15'h0);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].wr) begin
        send_req(1'b1, vecs[v].addr, vecs[v].len);
        for (int i = 0; i <= int'(vecs[v].len); i++) begin
          wr_beat(vecs[v].addr + ADDRESSSIZE'(i), vecs[v].base + WORDSIZE'(i));
        end
      end else begin
        rd_req(vecs[v].addr, vecs[v].len);
      end
      wait_drain();
    end

    // Write stall mid-burst: pins go idle, address resumes where it left off.
    send_req(1'b1, 15'h0200, 4'd3);
    wr_beat(15'h0200, 96'hD0);
    wr_beat(15'h0201, 96'hD1);
    for (int i = 0; i < 3; i++) begin
      @(posedge iClk); #1;
      check("stall_nce", oNCE, 1'b1);
      check("stall_wr_ready", bus.oWrReady, 1'b1);
    end
    wr_beat(15'h0202, 96'hD2);
    wr_beat(15'h0203, 96'hD3);
    rd_req(15'h0200, 4'd3);
    wait_drain();

    // Backpressure: FIFO fills to depth, pins stop, then all beats drain in order.
    bus.iRdReady = 1'b0;
    rd_req(15'h1234, 4'd15);
    repeat (20) @(posedge iClk);
    #1;
    check("bp_fifo_count", u_dut.fifo_count, 4);
    check("bp_nce", oNCE, 1'b1);
    check("bp_rd_valid", bus.oRdValid, 1'b1);
    check("bp_busy", bus.oBusy, 1'b1);
    check("bp_pending", sb_q.size(), 16);
    bus.iRdReady = 1'b1;
    wait_drain();

    // Reset mid-burst: pins idle at once, FIFO emptied, then a clean read.
    rd_req(15'h1234, 4'd15);
    repeat (3) @(posedge iClk);
    #1 iReset = 1'b1;
    #1;
    check("mrst_nce", oNCE, 1'b1);
    check("mrst_nwrt", oNWRT, 1'b1);
    check("mrst_rd_valid", bus.oRdValid, 1'b0);
    check("mrst_req_ready", bus.oReqReady, 1'b1);
    check("mrst_busy", bus.oBusy, 1'b0);
    sb_q.delete();
    tb_wr_beats = 0;
    tb_rd_pops  = 0;
    @(posedge iClk);
    #1 iReset = 1'b0;
    @(posedge iClk); #1;
    rd_req(15'h0010, 4'd3);
    wait_drain();

`ifdef SRAM_CTRL_STATS_EN
    check("stat_wr", oWrBeatCnt, tb_wr_beats);
    check("stat_rd", oRdBeatCnt, tb_rd_pops);
`else
    check("stat_wr", oWrBeatCnt, 16'd0);
    check("stat_rd", oRdBeatCnt, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
